// File: rtl/bus_decoder.sv
// 1-to-4 address decoder for the quasiSoC memory bus.
// Optional stall timeout: define BUS_TIMEOUT_EN.
module bus_decoder #(
  parameter logic [31:0] BASE0    = 32'h0000_0000,
  parameter logic [31:0] BASE1    = 32'h1000_0000,
  parameter logic [31:0] BASE2    = 32'h2000_0000,
  parameter logic [31:0] BASE3    = 32'h3000_0000,
  parameter logic [31:0] MASK0    = 32'hF000_0000,
  parameter logic [31:0] MASK1    = 32'hF000_0000,
  parameter logic [31:0] MASK2    = 32'hF000_0000,
  parameter logic [31:0] MASK3    = 32'hF000_0000,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF,
  parameter int          TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] d,
  input  logic        we,
  input  logic        rd,
  output logic [31:0] spo,
  output logic        ready,
  output logic [31:0] sa,
  output logic [31:0] sd,
  output logic [3:0]  swe,
  output logic [3:0]  srd,
  input  logic [31:0] sspo0,
  input  logic [31:0] sspo1,
  input  logic [31:0] sspo2,
  input  logic [31:0] sspo3,
  input  logic [3:0]  sready,
  output logic        err,
  output logic [31:0] err_addr,
  input  logic        err_clr
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FWD  = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  logic [1:0]  r_state;
  logic [1:0]  r_sel;
  logic [31:0] r_addr;
  logic        r_err;
  logic [31:0] r_err_addr;

  logic        w_req;
  logic [3:0]  w_match;
  logic        w_hit;
  logic [1:0]  w_idx;
  logic        w_sready;
  logic [31:0] w_sspo;
  logic        w_tmo;

  assign sa    = a;
  assign sd    = d;
  assign w_req = rd | we;

  assign w_match[0] = (a & MASK0) == BASE0;
  assign w_match[1] = (a & MASK1) == BASE1;
  assign w_match[2] = (a & MASK2) == BASE2;
  assign w_match[3] = (a & MASK3) == BASE3;
  assign w_hit      = |w_match;

  // Overlapping windows resolve to the lowest index.
  always_comb begin
    w_idx = 2'd0;
    priority case (1'b1)
      w_match[0]: w_idx = 2'd0;
      w_match[1]: w_idx = 2'd1;
      w_match[2]: w_idx = 2'd2;
      w_match[3]: w_idx = 2'd3;
      default:    w_idx = 2'd0;
    endcase
  end

  assign w_sready = sready[r_sel];

  always_comb begin
    w_sspo = 32'd0;
    unique case (r_sel)
      2'd0: w_sspo = sspo0;
      2'd1: w_sspo = sspo1;
      2'd2: w_sspo = sspo2;
      2'd3: w_sspo = sspo3;
      default: w_sspo = 32'd0;
    endcase
  end

`ifdef BUS_TIMEOUT_EN
  logic [15:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 16'd0;
    end else if (r_state != S_FWD) begin
      r_cnt <= 16'd0;
    end else if (!w_sready) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign w_tmo = (r_state == S_FWD) && !w_sready &&
                 (r_cnt == TMO_LAST);
`else
  logic w_unused_tmo;

  assign w_unused_tmo = ^TMO_LAST;
  assign w_tmo        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sel   <= 2'd0;
      r_addr  <= 32'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_addr <= a;
            if (w_hit) begin
              r_sel   <= w_idx;
              r_state <= S_FWD;
            end else begin
              r_state <= S_ERR;
            end
          end
        end
        S_FWD: begin
          if (w_sready) begin
            r_state <= S_IDLE;
          end else if (w_tmo) begin
            r_state <= S_ERR;
          end
        end
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A clear in the same cycle as a new error wins.
  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      r_err      <= 1'b0;
      r_err_addr <= 32'd0;
    end else if (r_state == S_ERR) begin
      r_err <= 1'b1;
      if (!r_err) begin
        r_err_addr <= r_addr;
      end
    end
  end

  assign err      = r_err;
  assign err_addr = r_err_addr;

  // Gated by rst so a reset aborts the access in the sampled cycle.
  always_comb begin
    swe   = 4'd0;
    srd   = 4'd0;
    ready = 1'b0;
    spo   = 32'd0;
    if (!rst) begin
      unique case (r_state)
        S_FWD: begin
          swe[r_sel] = we;
          srd[r_sel] = rd & ~we;
          ready      = w_sready;
          spo        = w_sspo;
        end
        S_ERR: begin
          ready = 1'b1;
          spo   = ERR_DATA;
        end
        default: begin
          ready = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_decoder.sv
// Bench for bus_decoder: transaction-level model and
// per-cycle output comparison under random traffic.
module tb_bus_decoder;

  localparam logic [31:0] EDATA = 32'hDEAD_BEEF;
  localparam logic [3:0][31:0] BASES = {
    32'h3000_0000, 32'h2000_0000,
    32'h1000_0000, 32'h0000_0000};
  localparam logic [3:0][31:0] MASKS = {
    32'hFFFF_0000, 32'hF000_0000,
    32'hF000_0000, 32'hF000_0000};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] d = '0;
  logic        we = 1'b0;
  logic        rd = 1'b0;
  logic [31:0] spo;
  logic        ready;
  logic [31:0] sa;
  logic [31:0] sd;
  logic [3:0]  swe;
  logic [3:0]  srd;
  logic [31:0] sv [4];
  logic [3:0]  sready = '0;
  logic        err;
  logic [31:0] err_addr;
  logic        err_clr = 1'b0;

  bus_decoder #(
    .MASK3(32'hFFFF_0000),
    .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .a(a), .d(d),
    .we(we), .rd(rd), .spo(spo), .ready(ready),
    .sa(sa), .sd(sd), .swe(swe), .srd(srd),
    .sspo0(sv[0]), .sspo1(sv[1]),
    .sspo2(sv[2]), .sspo3(sv[3]),
    .sready(sready), .err(err),
    .err_addr(err_addr), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic        chk_en = 1'b0;
  logic        clr_rand = 1'b0;
  logic [3:0]  e_swe = '0;
  logic [3:0]  e_srd = '0;
  logic        e_ready = 1'b0;
  logic [31:0] e_spo = '0;
  logic        m_err = 1'b0;
  logic [31:0] m_err_addr = '0;
  logic        cyc_err = 1'b0;
  logic [31:0] cyc_addr = '0;
  logic [31:0] cap_spo = '0;
  logic [3:0]  cap_swe = '0;
  logic [3:0]  cap_srd = '0;

  task automatic cmp(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int decode(input logic [31:0] x);
    for (int i = 0; i < 4; i++)
      if ((x & MASKS[i]) == BASES[i]) return i;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("swe", 32'(swe), 32'(e_swe));
      cmp("srd", 32'(srd), 32'(e_srd));
      cmp("ready", 32'(ready), 32'(e_ready));
      cmp("spo", spo, e_spo);
      cmp("sa", sa, a);
      cmp("sd", sd, d);
      cmp("err", 32'(err), 32'(m_err));
      cmp("err_addr", err_addr, m_err_addr);
      if (ready) begin
        cap_spo <= spo;
        cap_swe <= swe;
        cap_srd <= srd;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rst || err_clr) begin
      m_err      = 1'b0;
      m_err_addr = '0;
    end else if (cyc_err) begin
      if (!m_err) m_err_addr = cyc_addr;
      m_err = 1'b1;
    end
    cyc_err = 1'b0;
  endtask

  task automatic noise(input int idx);
    for (int i = 0; i < 4; i++) sv[i] = $urandom;
    sready = 4'($urandom);
    if (idx >= 0) sready[idx] = 1'b0;
    err_clr = clr_rand && ($urandom_range(0, 7) == 0);
  endtask

  task automatic expect_zero();
    e_swe = '0; e_srd = '0; e_ready = 1'b0; e_spo = '0;
  endtask

  task automatic idle_cycle();
    a = $urandom; d = $urandom; we = 1'b0; rd = 1'b0;
    noise(-1);
    expect_zero();
    step();
  endtask

  task automatic req_cycle(input logic [31:0] ad,
                           input logic [31:0] dd,
                           input logic w, input logic r);
    a = ad; d = dd; we = w; rd = r;
    noise(-1);
    expect_zero();
    step();
  endtask

  task automatic fwd_cycle(input int idx, input logic rdy,
                           input logic [31:0] rdata);
    noise(idx);
    if (rdy) begin
      sready[idx] = 1'b1;
      sv[idx]     = rdata;
    end
    expect_zero();
    if (we) e_swe[idx] = 1'b1;
    if (rd && !we) e_srd[idx] = 1'b1;
    e_ready = rdy;
    e_spo   = sv[idx];
    step();
  endtask

  task automatic err_cycle(input logic [31:0] ad);
    noise(-1);
    expect_zero();
    e_ready  = 1'b1;
    e_spo    = EDATA;
    cyc_err  = 1'b1;
    cyc_addr = ad;
    step();
  endtask

  task automatic rst_cycle();
    rst = 1'b1;
    noise(-1);
    expect_zero();
    step();
    rst = 1'b0;
  endtask

  task automatic txn(input logic [31:0] ad,
                     input logic [31:0] dd,
                     input logic w, input logic r,
                     input int lat, input int drop_at,
                     input logic [31:0] rdata);
    int idx;
    idx = decode(ad);
    req_cycle(ad, dd, w, r);
    if (idx < 0) begin
      err_cycle(ad);
    end else begin
      for (int c = 1; c <= lat; c++) begin
        if (c == drop_at) begin
          we = 1'b0;
          rd = 1'b0;
        end
        fwd_cycle(idx, c == lat, rdata);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ad;
    logic        w, r;
    for (int i = 0; i < 4; i++) sv[i] = '0;
    step();
    chk_en = 1'b1;
    rst_cycle();
    idle_cycle();

    cmp("dec_2000_0010", decode(32'h2000_0010), 32'd2);
    cmp("dec_0000_0004", decode(32'h0000_0004), 32'd0);
    cmp("dec_3001_0000", decode(32'h3001_0000), 32'hFFFF_FFFF);
    cmp("dec_3000_0040", decode(32'h3000_0040), 32'd3);

    txn(32'h2000_0010, 32'h0, 1'b0, 1'b1, 3, 0,
        32'h1234_5678);
    idle_cycle();
    cmp("rd2_spo", cap_spo, 32'h1234_5678);
    cmp("rd2_srd", 32'(cap_srd), 32'h4);

    txn(32'h0000_0004, 32'hCAFE_F00D, 1'b1, 1'b1, 2, 0,
        32'h0);
    idle_cycle();
    cmp("wr0_swe", 32'(cap_swe), 32'h1);
    cmp("wr0_srd", 32'(cap_srd), 32'h0);

    txn(32'h3001_0000, 32'h0, 1'b0, 1'b1, 1, 0, 32'h0);
    idle_cycle();
    cmp("err_spo", cap_spo, 32'hDEAD_BEEF);
    cmp("err_set", 32'(err), 32'h1);
    cmp("err_addr1", err_addr, 32'h3001_0000);
    txn(32'h5000_0000, 32'h0, 1'b1, 1'b0, 1, 0, 32'h0);
    idle_cycle();
    cmp("err_addr2", err_addr, 32'h3001_0000);
    err_clr = 1'b1;
    a = '0; we = 1'b0; rd = 1'b0;
    expect_zero();
    step();
    err_clr = 1'b0;
    cmp("clr_err", 32'(err), 32'h0);
    cmp("clr_addr", err_addr, 32'h0);

    txn(32'h1000_0020, 32'h0, 1'b0, 1'b1, 2, 0,
        32'hAAAA_0001);
    txn(32'h3000_0040, 32'h0, 1'b0, 1'b1, 1, 0,
        32'hBBBB_0003);
    cmp("b2b_spo", cap_spo, 32'hBBBB_0003);
    cmp("b2b_srd", 32'(cap_srd), 32'h8);
    idle_cycle();

    req_cycle(32'h1000_0000, 32'h0, 1'b0, 1'b1);
    repeat (3) fwd_cycle(1, 1'b0, 32'h0);
    rst_cycle();
    txn(32'h2000_0100, 32'h0, 1'b0, 1'b1, 1, 0,
        32'h0F0F_0F0F);
    idle_cycle();
    cmp("post_rst_spo", cap_spo, 32'h0F0F_0F0F);

`ifdef BUS_TIMEOUT_EN
    req_cycle(32'h1000_0100, 32'h0, 1'b0, 1'b1);
    repeat (8) fwd_cycle(1, 1'b0, 32'h0);
    err_cycle(32'h1000_0100);
    idle_cycle();
    cmp("tmo_spo", cap_spo, 32'hDEAD_BEEF);
    cmp("tmo_err", 32'(err), 32'h1);
    cmp("tmo_addr", err_addr, 32'h1000_0100);
`else
    req_cycle(32'h1000_0100, 32'h0, 1'b0, 1'b1);
    repeat (1000) fwd_cycle(1, 1'b0, 32'h0);
    rst_cycle();
`endif
    idle_cycle();

    clr_rand = 1'b1;
    for (int t = 0; t < 400; t++) begin
      ad = $urandom;
      ad[31:28] = 4'($urandom_range(0, 5));
      if (ad[31:28] == 4'h3 && $urandom_range(0, 1) == 1)
        ad[27:16] = '0;
      w = 1'($urandom);
      r = w ? 1'($urandom) : 1'b1;
      txn(ad, $urandom, w, r, $urandom_range(1, 5),
          ($urandom_range(0, 3) == 0) ?
            $urandom_range(2, 5) : 0,
          $urandom);
      repeat ($urandom_range(0, 2)) idle_cycle();
    end
    clr_rand = 1'b0;
    err_clr  = 1'b0;
    idle_cycle();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
